// File: rtl/noc_resp_rx.sv
// NOC2 response receiver: parses header/payload flits, checks payload against
// bench-supplied expected data, captures payload in a FWFT FIFO, keeps stats.
module noc_resp_rx #(
  parameter int         DATA_WIDTH = 64,
  parameter int         CAP_DEPTH  = 16,
  parameter int         CAP_AW     = 4,
  parameter logic [3:0] RX_IDLE    = 4'h1,
  parameter logic [3:0] RX_DATA    = 4'h2,
  parameter logic [3:0] RX_DONE    = 4'h8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  noc_out_valid,
  input  logic [DATA_WIDTH-1:0] noc_out_data,
  output logic                  noc_out_rdy,
  input  logic                  chk_en,
  input  logic [47:0]           exp_base,
  output logic [47:0]           exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  cap_rd_en,
  output logic [DATA_WIDTH-1:0] cap_rd_data,
  output logic                  cap_empty,
  output logic                  cap_full,
  output logic                  msg_done,
  output logic [7:0]            last_len,
  output logic [7:0]            last_type,
  output logic [7:0]            last_mshr,
  output logic [15:0]           msg_cnt,
  output logic [15:0]           flit_cnt,
  output logic [15:0]           err_cnt,
  output logic                  err_flag
);

  typedef enum logic [3:0] {
    S_IDLE = RX_IDLE,
    S_DATA = RX_DATA,
    S_DONE = RX_DONE
  } rx_state_e;

  localparam logic [CAP_AW:0] FULL_CNT = (CAP_AW+1)'(CAP_DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rx_state_e             state_q, state_d;
  logic [7:0]            beat_q, len_q, type_q, mshr_q;
  logic [47:0]           addr_q;
  logic [15:0]           msg_q, flit_q, err_q;
  logic                  eflag_q;
  logic [CAP_AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CAP_AW:0]       cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [CAP_DEPTH];

  logic accept, hdr_acc, dat_acc, done, push, pop, mism;
  logic [7:0] hdr_len;

  assign hdr_len   = noc_out_data[29:22];
  assign cap_empty = (cnt_q == '0);
  assign cap_full  = (cnt_q == FULL_CNT);
  // Ready is forced low during reset so nothing is taken while the block is held.
  assign noc_out_rdy = reset_ && !cap_full && (state_q == S_IDLE || state_q == S_DATA);
  assign accept    = noc_out_valid && noc_out_rdy;
  assign push      = dat_acc;
  assign pop       = cap_rd_en && !cap_empty;
  assign mism      = dat_acc && chk_en && (noc_out_data != exp_data);

  always_comb begin
    state_d = state_q;
    hdr_acc = 1'b0;
    dat_acc = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        hdr_acc = 1'b1;
        state_d = (hdr_len == 8'd0) ? S_DONE : S_DATA;
      end
      S_DATA: if (accept) begin
        dat_acc = 1'b1;
        if (beat_q == len_q - 8'd1) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      type_q  <= '0;
      mshr_q  <= '0;
      addr_q  <= '0;
      msg_q   <= '0;
      flit_q  <= '0;
      err_q   <= '0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hdr_acc) begin
        len_q  <= hdr_len;
        type_q <= noc_out_data[21:14];
        mshr_q <= noc_out_data[13:6];
        beat_q <= '0;
        addr_q <= exp_base;
      end
      if (dat_acc) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= addr_q + 48'd1;
      end
      if (hdr_acc || dat_acc) flit_q <= sat_inc(flit_q);
      if (mism) begin
        err_q   <= sat_inc(err_q);
        eflag_q <= 1'b1;
      end
      if (done) msg_q <= sat_inc(msg_q);
    end
  end

  // Capture FIFO: pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= noc_out_data;
  end

  assign cap_rd_data = mem_q[rd_ptr_q];
  assign msg_done    = (state_q == S_DONE);
  assign exp_addr    = addr_q;
  assign last_len    = len_q;
  assign last_type   = type_q;
  assign last_mshr   = mshr_q;
  assign msg_cnt     = msg_q;
  assign flit_cnt    = flit_q;
  assign err_cnt     = err_q;
  assign err_flag    = eflag_q;

endmodule
